rob_alloc_ctrl: RTL and testbench

- Allocation/retirement controller for the reorder buffer of the 2-wide rename pipeline.
- Hands out up to two ROB tags per cycle to the RNR stage; these tags become the destination mappings written into the rename tables.
- Frees up to two tags per cycle at COM.
- Generates the RNR full-stall and performs in-order pointer recovery on a flush.

---
 rtl/rob_alloc_ctrl.sv | 99 +++++++++
 tb/tb_rob_alloc_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rob_alloc_ctrl.sv
// Reorder-buffer tag allocator/retirer for a 2-wide rename stage.
// Hands out up to two tags per cycle, frees up to two at commit, and recovers the tail on a flush.
module rob_alloc_ctrl #(
    parameter int DEPTH = 32,
    parameter int PTR_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             recover,
    input  logic             stall_in,
    input  logic             alloc1_req,
    input  logic             alloc2_req,
    input  logic             com1_en,
    input  logic             com2_en,
    output logic [PTR_W-1:0] alloc1_tag,
    output logic [PTR_W-1:0] alloc2_tag,
    output logic             alloc_grant,
    output logic             stall_RNR,
    output logic [PTR_W-1:0] head_tag,
    output logic [PTR_W:0]   count,
    output logic             empty,
    output logic             full,
    output logic             err
);

    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [PTR_W:0] DEPTH_W = DEPTH[PTR_W:0];

    // Pointers carry the wrap bit in the MSB, so a plain add toggles it on roll-over.
    state_t           state_reg;
    logic [PTR_W:0]   head_ptr_reg;
    logic [PTR_W:0]   tail_ptr_reg;
    logic             err_reg;

    logic [1:0]       need;
    logic [1:0]       ret;
    logic [PTR_W:0]   need_ext;
    logic [PTR_W:0]   ret_ext;
    logic [PTR_W:0]   free_cnt;
    logic [PTR_W:0]   head_ptr_next;
    logic             ret_bad;
    logic [PTR_W-1:0] tail_idx;

    assign count    = tail_ptr_reg - head_ptr_reg;
    assign free_cnt = DEPTH_W - count;
    assign need     = {1'b0, alloc1_req} + {1'b0, alloc2_req};
    assign ret      = {1'b0, com1_en} + {1'b0, com1_en & com2_en};
    assign need_ext = {{(PTR_W-1){1'b0}}, need};
    assign ret_ext  = {{(PTR_W-1){1'b0}}, ret};

    assign ret_bad       = (com2_en & ~com1_en) | (ret_ext > count);
    assign head_ptr_next = ret_bad ? head_ptr_reg : head_ptr_reg + ret_ext;

    assign tail_idx   = tail_ptr_reg[PTR_W-1:0];
    assign alloc1_tag = tail_idx;
    assign alloc2_tag = alloc1_req ? tail_idx + {{(PTR_W-1){1'b0}}, 1'b1} : tail_idx;

    // Allocation sees only the registered count; same-cycle retirement frees space next cycle.
    assign alloc_grant = (state_reg == RUN) & ~recover & ~stall_in & (need != 2'd0)
                       & (free_cnt >= need_ext);
    assign stall_RNR   = (state_reg == FLUSH) | ((state_reg == RUN) & (need_ext > free_cnt));

    assign head_tag = head_ptr_reg[PTR_W-1:0];
    assign empty    = (count == '0);
    assign full     = (count == DEPTH_W);
    assign err      = err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= RUN;
            head_ptr_reg <= '0;
            tail_ptr_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            head_ptr_reg <= head_ptr_next;
            err_reg      <= err_reg | ret_bad;
            case (state_reg)
                RUN: begin
                    if (recover) begin
                        state_reg    <= FLUSH;
                        tail_ptr_reg <= head_ptr_next;
                    end else if (alloc_grant) begin
                        tail_ptr_reg <= tail_ptr_reg + need_ext;
                    end
                end
                FLUSH: begin
                    if (recover) begin
                        tail_ptr_reg <= head_ptr_next;
                    end else begin
                        state_reg <= RUN;
                    end
                end
                default: state_reg <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Bench for rob_alloc_ctrl: directed scenarios plus random traffic, checked against
// a head/occupancy model of the ROB.
module tb_rob_alloc_ctrl;

    localparam int DEPTH = 32;
    localparam int PTR_W = 5;

    logic             clk = 1'b0;
    logic             rst, recover, stall_in;
    logic             alloc1_req, alloc2_req, com1_en, com2_en;
    logic [PTR_W-1:0] alloc1_tag, alloc2_tag, head_tag;
    logic             alloc_grant, stall_RNR, empty, full, err;
    logic [PTR_W:0]   count;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: oldest entry index, occupancy, sticky error, in-flush flag.
    int m_head, m_count;
    bit m_err, m_flush, m_valid;

    rob_alloc_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst(rst), .recover(recover), .stall_in(stall_in),
        .alloc1_req(alloc1_req), .alloc2_req(alloc2_req),
        .com1_en(com1_en), .com2_en(com2_en),
        .alloc1_tag(alloc1_tag), .alloc2_tag(alloc2_tag),
        .alloc_grant(alloc_grant), .stall_RNR(stall_RNR),
        .head_tag(head_tag), .count(count), .empty(empty), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int m_need();
        return int'(alloc1_req) + int'(alloc2_req);
    endfunction

    function automatic bit m_grant();
        return !m_flush && !recover && !stall_in && m_need() > 0 && m_need() <= DEPTH - m_count;
    endfunction

    task automatic check_model(input string tag);
        int tail;
        int exp_t2;
        bit exp_stall;
        tail      = (m_head + m_count) % DEPTH;
        exp_t2    = alloc1_req ? (tail + 1) % DEPTH : tail;
        exp_stall = m_flush || (m_need() > DEPTH - m_count);
        check_eq({tag, ".tag1"},  32'(alloc1_tag), 32'(tail));
        check_eq({tag, ".tag2"},  32'(alloc2_tag), 32'(exp_t2));
        check_eq({tag, ".grant"}, 32'(alloc_grant), 32'(m_grant()));
        check_eq({tag, ".stall"}, 32'(stall_RNR), 32'(exp_stall));
        check_eq({tag, ".head"},  32'(head_tag), 32'(m_head));
        check_eq({tag, ".count"}, 32'(count), 32'(m_count));
        check_eq({tag, ".empty"}, 32'(empty), 32'(m_count == 0));
        check_eq({tag, ".full"},  32'(full), 32'(m_count == DEPTH));
        check_eq({tag, ".err"},   32'(err), 32'(m_err));
    endtask

    task automatic drive(input bit a1, input bit a2, input bit c1, input bit c2,
                         input bit rec, input bit stl, input bit rs);
        alloc1_req = a1; alloc2_req = a2; com1_en = c1; com2_en = c2;
        recover = rec; stall_in = stl; rst = rs;
        #1;
    endtask

    // Advance one clock edge and apply the same edge to the model.
    task automatic tick();
        int  ret;
        bit  bad;
        bit  g;
        @(posedge clk);
        if (rst) begin
            m_head = 0; m_count = 0; m_err = 0; m_flush = 0; m_valid = 1;
        end else begin
            g   = m_grant();
            ret = com1_en ? (com2_en ? 2 : 1) : 0;
            bad = (com2_en && !com1_en) || ret > m_count;
            if (!bad) begin
                m_head  = (m_head + ret) % DEPTH;
                m_count = m_count - ret;
            end
            m_err = m_err | bad;
            if (recover) begin
                m_count = 0;
                m_flush = 1;
            end else begin
                if (g) m_count = m_count + m_need();
                m_flush = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic step(input string tag, input bit a1, input bit a2, input bit c1,
                        input bit c2, input bit rec, input bit stl, input bit rs);
        drive(a1, a2, c1, c2, rec, stl, rs);
        if (m_valid) check_model(tag);
        tick();
        $display("%s: a=%0b%0b c=%0b%0b rec=%0b stl=%0b rst=%0b -> count=%0d head=%0d err=%0b",
                 tag, a1, a2, c1, c2, rec, stl, rs, count, head_tag, err);
    endtask

    task automatic do_reset();
        step("reset", 0, 0, 0, 0, 0, 0, 1);
        step("idle", 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        m_valid = 0; m_head = 0; m_count = 0; m_err = 0; m_flush = 0;
        drive(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        do_reset();

        // Reset state
        drive(0, 0, 0, 0, 0, 0, 0);
        check_eq("rst.count", 32'(count), 0);
        check_eq("rst.empty", 32'(empty), 1);
        check_eq("rst.grant", 32'(alloc_grant), 0);
        check_eq("rst.stall", 32'(stall_RNR), 0);

        // Three dual allocations: tags (0,1),(2,3),(4,5)
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 0, 0, 0);
            check_model("dual");
            check_eq("dual.tag1", 32'(alloc1_tag), 32'(2 * i));
            check_eq("dual.tag2", 32'(alloc2_tag), 32'(2 * i + 1));
            check_eq("dual.grant", 32'(alloc_grant), 1);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        check_eq("dual.count", 32'(count), 6);
        check_eq("dual.head", 32'(head_tag), 0);

        // Fill to 31, then a pair request stalls while one entry retires
        for (int i = 0; i < 12; i++) step("fill", 1, 1, 0, 0, 0, 0, 0);
        step("fill1", 1, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 0, 0, 0, 0);
        check_model("near_full");
        check_eq("near_full.stall", 32'(stall_RNR), 1);
        check_eq("near_full.grant", 32'(alloc_grant), 0);
        tick();
        drive(1, 1, 0, 0, 0, 0, 0);
        check_model("wrap");
        check_eq("wrap.count", 32'(count), 30);
        check_eq("wrap.tag1", 32'(alloc1_tag), 31);
        check_eq("wrap.tag2", 32'(alloc2_tag), 0);
        tick();

        // Full: dual retire plus pair request -> no grant, then grant
        drive(1, 1, 1, 1, 0, 0, 0);
        check_model("full");
        check_eq("full.full", 32'(full), 1);
        check_eq("full.grant", 32'(alloc_grant), 0);
        tick();
        drive(1, 1, 0, 0, 0, 0, 0);
        check_model("full2");
        check_eq("full2.count", 32'(count), 30);
        check_eq("full2.grant", 32'(alloc_grant), 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check_eq("full3.count", 32'(count), 32);

        // Lone slot-2 request at tail=7, then illegal com2-only retire
        do_reset();
        for (int i = 0; i < 7; i++) step("single", 1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        check_model("lone2");
        check_eq("lone2.tag2", 32'(alloc2_tag), 7);
        tick();
        step("com2only", 0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        check_model("com2only.after");
        check_eq("com2only.err", 32'(err), 1);
        check_eq("com2only.head", 32'(head_tag), 0);
        check_eq("com2only.count", 32'(count), 8);

        // Recover with count=10, head=3
        do_reset();
        for (int i = 0; i < 6; i++) step("pre", 1, 1, 0, 0, 0, 0, 0);
        step("pre1", 1, 0, 0, 0, 0, 0, 0);
        step("ret2", 0, 0, 1, 1, 0, 0, 0);
        step("ret1", 0, 0, 1, 0, 0, 0, 0);
        drive(1, 1, 1, 1, 1, 0, 0);
        check_eq("pre_rec.count", 32'(count), 10);
        check_eq("pre_rec.head", 32'(head_tag), 3);
        check_model("rec");
        tick();
        drive(1, 1, 0, 0, 0, 0, 0);
        check_model("flush");
        check_eq("flush.head", 32'(head_tag), 5);
        check_eq("flush.count", 32'(count), 0);
        check_eq("flush.stall", 32'(stall_RNR), 1);
        check_eq("flush.grant", 32'(alloc_grant), 0);
        tick();
        drive(1, 1, 0, 0, 0, 0, 0);
        check_model("post_flush");
        check_eq("post_flush.grant", 32'(alloc_grant), 1);
        check_eq("post_flush.tag1", 32'(alloc1_tag), 5);
        check_eq("post_flush.tag2", 32'(alloc2_tag), 6);
        tick();

        // Reset in the middle of a flush, with err already set
        step("c2bad", 1, 1, 0, 1, 0, 0, 0);
        step("rec2", 0, 0, 0, 0, 1, 0, 0);
        step("rst_in_flush", 1, 1, 0, 0, 1, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        check_model("after_rst");
        check_eq("after_rst.err", 32'(err), 0);
        check_eq("after_rst.stall", 32'(stall_RNR), 0);
        check_eq("after_rst.count", 32'(count), 0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit a1, a2, c1, c2, rec, stl, rs;
            a1  = ($urandom_range(3) != 0);
            a2  = ($urandom_range(3) != 0);
            c1  = ($urandom_range(2) == 0);
            c2  = ($urandom_range(1) == 0);
            rec = ($urandom_range(40) == 0);
            stl = ($urandom_range(7) == 0);
            rs  = ($urandom_range(150) == 0);
            step("rand", a1, a2, c1, c2, rec, stl, rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
